// File: rtl/axi_res_flit_serializer.sv
// HMC response-path serializer: buffers FPW-flit AXI4-Stream beats and emits
// one 128-bit FLIT per handshake, skipping invalid lanes and checking packet framing.
module axi_res_flit_serializer #(
    parameter int FPW   = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     res,
    output logic                     s_tready,
    input  logic                     s_tvalid,
    input  logic [FPW*128-1:0]       s_tdata,
    input  logic [FPW*16-1:0]        s_tuser,
    output logic                     m_flit_valid,
    input  logic                     m_flit_ready,
    output logic [127:0]             m_flit_data,
    output logic                     m_flit_hdr,
    output logic                     m_flit_tail,
    output logic [CNT_W-1:0]         pkt_cnt,
    output logic                     err_hdr_in_pkt,
    output logic                     err_no_hdr,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int DW = FPW * 128;
    localparam int UW = FPW * 16;
    localparam int FW = 3 * FPW;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [DW-1:0]    data_mem [DEPTH];
    logic [FW-1:0]    flag_mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      level_reg, level_next;
    logic [FPW-1:0]   consumed_reg, consumed_next;
    logic             in_pkt_reg, in_pkt_next;
    logic [CNT_W-1:0] pkt_cnt_reg, pkt_cnt_next;
    logic             err_hdr_reg, err_hdr_next;
    logic             err_no_hdr_reg, err_no_hdr_next;

    logic [DW-1:0]    head_data;
    logic [FW-1:0]    head_flags;
    logic [FPW-1:0]   head_valid, head_hdr, head_tail;
    logic [FPW-1:0]   remaining, sel_onehot;
    logic [127:0]     lane_data [FPW];
    logic [127:0]     sel_data;
    logic             sel_hdr, sel_tail, last_lane;
    logic             out_valid, fire, push, pop;

    // Only the per-lane flag bits are kept; the rest of TUSER is reserved.
    logic             unused_tuser;
    assign unused_tuser = ^s_tuser[UW-1:FW];

    assign s_tready  = (level_reg != LEVEL_FULL) && !res;
    assign out_valid = (level_reg != '0) && !res;
    // Zero-valid beats are handshaken but never written.
    assign push      = s_tvalid && s_tready && (|s_tuser[FPW-1:0]);
    assign fire      = out_valid && m_flit_ready;
    assign pop       = fire && last_lane;

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= s_tdata;
            flag_mem[wr_ptr_reg] <= s_tuser[FW-1:0];
        end
    end

    // Head read is asynchronous so the next beat follows without a bubble.
    assign head_data  = data_mem[rd_ptr_reg];
    assign head_flags = flag_mem[rd_ptr_reg];
    assign head_valid = head_flags[FPW-1:0];
    assign head_hdr   = head_flags[2*FPW-1:FPW];
    assign head_tail  = head_flags[3*FPW-1:2*FPW];

    assign remaining  = head_valid & ~consumed_reg;
    assign sel_onehot = remaining & (~remaining + FPW'(1));
    assign last_lane  = ((remaining & ~sel_onehot) == '0);
    assign sel_hdr    = |(sel_onehot & head_hdr);
    assign sel_tail   = |(sel_onehot & head_tail);

    generate
        for (genvar gi = 0; gi < FPW; gi++) begin : g_lane
            assign lane_data[gi] = head_data[128*gi +: 128];
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < FPW; i++) begin
            sel_data = sel_data | ({128{sel_onehot[i]}} & lane_data[i]);
        end
    end

    always_comb begin
        wr_ptr_next     = wr_ptr_reg + AW'(push);
        rd_ptr_next     = rd_ptr_reg + AW'(pop);
        level_next      = level_reg + (AW + 1)'(push) - (AW + 1)'(pop);
        consumed_next   = consumed_reg;
        in_pkt_next     = in_pkt_reg;
        pkt_cnt_next    = pkt_cnt_reg;
        err_hdr_next    = err_hdr_reg && !err_clr;
        err_no_hdr_next = err_no_hdr_reg && !err_clr;
        if (fire) begin
            consumed_next = pop ? '0 : (consumed_reg | sel_onehot);
            if (sel_hdr && in_pkt_reg) begin
                err_hdr_next = 1'b1;
            end
            if (!sel_hdr && !in_pkt_reg) begin
                err_no_hdr_next = 1'b1;
            end
            if (sel_tail) begin
                in_pkt_next  = 1'b0;
                pkt_cnt_next = pkt_cnt_reg + CNT_W'(1);
            end else if (sel_hdr) begin
                in_pkt_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            consumed_reg   <= '0;
            in_pkt_reg     <= 1'b0;
            pkt_cnt_reg    <= '0;
            err_hdr_reg    <= 1'b0;
            err_no_hdr_reg <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            level_reg      <= level_next;
            consumed_reg   <= consumed_next;
            in_pkt_reg     <= in_pkt_next;
            pkt_cnt_reg    <= pkt_cnt_next;
            err_hdr_reg    <= err_hdr_next;
            err_no_hdr_reg <= err_no_hdr_next;
        end
    end

    assign m_flit_valid   = out_valid;
    assign m_flit_data    = out_valid ? sel_data : '0;
    assign m_flit_hdr     = out_valid && sel_hdr;
    assign m_flit_tail    = out_valid && sel_tail;
    assign pkt_cnt        = pkt_cnt_reg;
    assign err_hdr_in_pkt = err_hdr_reg;
    assign err_no_hdr     = err_no_hdr_reg;
    assign fifo_level     = level_reg;

endmodule

// File: tb/tb_axi_res_flit_serializer.sv
// Directed bench for axi_res_flit_serializer (FPW=2, DEPTH=4): framing,
// lane skipping, full-FIFO backpressure, sticky errors and mid-packet reset.
module tb_axi_res_flit_serializer;

    logic         clk = 1'b0;
    logic         res;
    logic         s_tready;
    logic         s_tvalid;
    logic [255:0] s_tdata;
    logic [31:0]  s_tuser;
    logic         m_flit_valid;
    logic         m_flit_ready;
    logic [127:0] m_flit_data;
    logic         m_flit_hdr;
    logic         m_flit_tail;
    logic [15:0]  pkt_cnt;
    logic         err_hdr_in_pkt;
    logic         err_no_hdr;
    logic         err_clr;
    logic [2:0]   fifo_level;

    int checks = 0;
    int errors = 0;

    axi_res_flit_serializer #(.FPW(2), .DEPTH(4), .CNT_W(16)) dut (
        .clk            (clk),
        .res            (res),
        .s_tready       (s_tready),
        .s_tvalid       (s_tvalid),
        .s_tdata        (s_tdata),
        .s_tuser        (s_tuser),
        .m_flit_valid   (m_flit_valid),
        .m_flit_ready   (m_flit_ready),
        .m_flit_data    (m_flit_data),
        .m_flit_hdr     (m_flit_hdr),
        .m_flit_tail    (m_flit_tail),
        .pkt_cnt        (pkt_cnt),
        .err_hdr_in_pkt (err_hdr_in_pkt),
        .err_no_hdr     (err_no_hdr),
        .err_clr        (err_clr),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk_user(input logic [1:0] v, input logic [1:0] h, input logic [1:0] t);
        return {26'b0, t, h, v};
    endfunction

    // Drive one beat for exactly one edge (caller ensures s_tready is high).
    task automatic send_beat(input logic [255:0] d, input logic [31:0] u);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        tick();
        s_tvalid = 1'b0;
    endtask

    logic [127:0] exp_flit;

    initial begin
        res = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0;
        m_flit_ready = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_tready", s_tready, 1'b0);
        chk("rst_valid", m_flit_valid, 1'b0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_cnt", pkt_cnt, 16'd0);
        chk("rst_errs", {err_hdr_in_pkt, err_no_hdr}, 2'b00);
        res = 1'b0;
        #1;
        chk("post_rst_tready", s_tready, 1'b1);

        // Two-flit packet in one beat: A (hdr) then B (tail)
        m_flit_ready = 1'b1;
        send_beat({128'hBBBB, 128'hAAAA}, mk_user(2'b11, 2'b01, 2'b10));
        chk("t1_valid", m_flit_valid, 1'b1);
        chk("t1_level", fifo_level, 3'd1);
        chk("t1_a_data", m_flit_data, 128'hAAAA);
        chk("t1_a_flags", {m_flit_hdr, m_flit_tail}, 2'b10);
        tick();
        chk("t1_b_data", m_flit_data, 128'hBBBB);
        chk("t1_b_flags", {m_flit_hdr, m_flit_tail}, 2'b01);
        tick();
        chk("t1_valid_end", m_flit_valid, 1'b0);
        chk("t1_cnt", pkt_cnt, 16'd1);
        chk("t1_errs", {err_hdr_in_pkt, err_no_hdr}, 2'b00);

        // Sparse beat: only lane 1 valid, single-flit packet C
        send_beat({128'hCCCC, 128'hDEAD}, mk_user(2'b10, 2'b10, 2'b10));
        chk("t2_data", m_flit_data, 128'hCCCC);
        chk("t2_flags", {m_flit_hdr, m_flit_tail}, 2'b11);
        tick();
        chk("t2_valid_end", m_flit_valid, 1'b0);
        chk("t2_cnt", pkt_cnt, 16'd2);
        chk("t2_errs", {err_hdr_in_pkt, err_no_hdr}, 2'b00);

        // Backpressure: fill 4 beats, 5th held until space frees up
        m_flit_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_beat({120'h0, 4'(k), 4'h1, 120'h0, 4'(k), 4'h0}, mk_user(2'b11, 2'b01, 2'b10));
        end
        s_tvalid = 1'b1;
        s_tdata  = {120'h0, 8'h41, 120'h0, 8'h40};
        s_tuser  = mk_user(2'b11, 2'b01, 2'b10);
        #1;
        chk("t3_full_level", fifo_level, 3'd4);
        chk("t3_full_tready", s_tready, 1'b0);
        tick();
        chk("t3_held_level", fifo_level, 3'd4);
        chk("t3_held_data", m_flit_data, 128'h00);
        m_flit_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            logic acc;
            exp_flit = {120'h0, 4'(f / 2), 4'(f % 2)};
            chk($sformatf("t3_flit%0d", f), m_flit_data, exp_flit);
            chk($sformatf("t3_hdr%0d", f), m_flit_hdr, (f % 2) == 0);
            acc = s_tvalid && s_tready;
            tick();
            if (acc) s_tvalid = 1'b0;
        end
        chk("t3_level_end", fifo_level, 3'd0);
        chk("t3_valid_end", m_flit_valid, 1'b0);
        chk("t3_cnt", pkt_cnt, 16'd7);

        // Zero-valid beat is dropped
        s_tvalid = 1'b1; s_tuser = mk_user(2'b00, 2'b11, 2'b11); s_tdata = '1;
        #1;
        chk("t4_tready", s_tready, 1'b1);
        tick();
        s_tvalid = 1'b0;
        chk("t4_level", fifo_level, 3'd0);
        chk("t4_valid", m_flit_valid, 1'b0);

        // Header while packet open -> err_hdr_in_pkt
        send_beat({128'h0, 128'h1111}, mk_user(2'b01, 2'b01, 2'b00));
        tick();
        chk("t5_no_err_yet", err_hdr_in_pkt, 1'b0);
        send_beat({128'h0, 128'h2222}, mk_user(2'b01, 2'b01, 2'b00));
        tick();
        chk("t5_err_hdr", err_hdr_in_pkt, 1'b1);
        chk("t5_err_nohdr0", err_no_hdr, 1'b0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t5_clr", err_hdr_in_pkt, 1'b0);
        // Tail closes the restarted packet cleanly
        send_beat({128'h0, 128'h3333}, mk_user(2'b01, 2'b00, 2'b01));
        tick();
        chk("t5_close_err", err_no_hdr, 1'b0);
        chk("t5_close_cnt", pkt_cnt, 16'd8);
        // Tail with no open packet -> err_no_hdr
        send_beat({128'h0, 128'h4444}, mk_user(2'b01, 2'b00, 2'b01));
        tick();
        chk("t5_err_nohdr", err_no_hdr, 1'b1);
        chk("t5_cnt2", pkt_cnt, 16'd9);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t5_clr2", err_no_hdr, 1'b0);
        // Set and clear on the same edge: set wins
        send_beat({128'h0, 128'h5555}, mk_user(2'b01, 2'b00, 2'b01));
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t5_set_wins", err_no_hdr, 1'b1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t5_clr3", err_no_hdr, 1'b0);

        // Reset in the middle of a 3-flit packet
        send_beat({128'h6662, 128'h6661}, mk_user(2'b11, 2'b01, 2'b00));
        send_beat({128'h0, 128'h6663}, mk_user(2'b01, 2'b00, 2'b01));
        chk("t6_mid_data", m_flit_data, 128'h6662);
        res = 1'b1;
        #1;
        chk("t6_res_valid", m_flit_valid, 1'b0);
        chk("t6_res_tready", s_tready, 1'b0);
        tick();
        res = 1'b0;
        chk("t6_level", fifo_level, 3'd0);
        chk("t6_cnt", pkt_cnt, 16'd0);
        chk("t6_data", m_flit_data, 128'h0);
        send_beat({128'h7772, 128'h7771}, mk_user(2'b11, 2'b01, 2'b10));
        chk("t6_clean_a", m_flit_data, 128'h7771);
        tick();
        chk("t6_clean_b", m_flit_data, 128'h7772);
        tick();
        chk("t6_clean_cnt", pkt_cnt, 16'd1);
        chk("t6_clean_errs", {err_hdr_in_pkt, err_no_hdr}, 2'b00);
        chk("t6_clean_valid", m_flit_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_res_flit_serializer.md
Name: axi_res_flit_serializer

Overview:
- Receive side of the HMC controller response path.
- Accepts FPW-flit-wide AXI4-Stream response beats carrying per-lane Valid/Hdr/Tail flags in TUSER, and buffers them in a DEPTH-beat FIFO.
- Emits one 128-bit FLIT per handshake with its header/tail flags, skipping invalid lanes.
- Tracks packet framing: counts completed packets and flags framing violations with sticky error bits.

Parameters:
- FPW, 2, FLITs per beat; DWIDTH = FPW*128, TUSER width = FPW*16.
- DEPTH, 4, FIFO depth in beats; power of 2, minimum 2.
- CNT_W, 16, width of the packet counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- res  input  1  synchronous reset, active-high.
- s_tready  output  1  beat accept.
- s_tvalid  input  1  beat valid.
- s_tdata  input  FPW*128  beat data; lane i = bits [128*i+127:128*i].
- s_tuser  input  FPW*16  Valid=[FPW-1:0], Hdr=[2FPW-1:FPW], Tail=[3FPW-1:2FPW]; upper bits ignored.
- m_flit_valid  output  1  FLIT available.
- m_flit_ready  input  1  FLIT consumed.
- m_flit_data  output  128  FLIT payload.
- m_flit_hdr  output  1  FLIT is a packet header.
- m_flit_tail  output  1  FLIT is a packet tail.
- pkt_cnt  output  CNT_W  count of tail FLITs delivered.
- err_hdr_in_pkt  output  1  sticky: header seen while a packet is open.
- err_no_hdr  output  1  sticky: non-header FLIT seen while no packet is open.
- err_clr  input  1  clears both sticky errors.
- fifo_level  output  $clog2(DEPTH)+1  beats stored.

Behaviour:
- Reset: `res` is sampled on the clk edge. While asserted, all outputs are 0, the FIFO is flushed, the lane mask is cleared and in_pkt = 0. Reset mid-packet discards all buffered and partial data with no error raised.
- Input accept:
  - s_tready = (fifo_level != DEPTH) && !res.
  - A beat is accepted on s_tvalid && s_tready.
  - A pop in the same cycle does not raise s_tready when the FIFO is full.
  - Only s_tdata plus 3*FPW flag bits are stored.
- Zero-Valid beat (Valid == 0): accepted and dropped. It is not stored and fifo_level is unchanged.
- Latency: a beat accepted at edge N drives m_flit_* after edge N. There is no combinational path from s_* to m_*.
- Lane selection:
  - remaining mask = head Valid & ~consumed.
  - The output lane is the lowest set bit of remaining mask.
  - m_flit_valid = (fifo_level != 0).
  - m_flit_data/hdr/tail come from the selected lane of the FIFO head.
  - Outputs hold stable while m_flit_valid && !m_flit_ready.
- Output handshake (m_flit_valid && m_flit_ready):
  - The selected lane is marked consumed.
  - If no bits remain, the head beat is popped and consumed is cleared in the same edge.
  - Next FLIT: next valid lane of the same beat, or lane-lowest of the next beat, on the following cycle. No bubble between beats.
- Simultaneous push and pop: both take effect and fifo_level is unchanged. Read/write pointers wrap modulo DEPTH; level is tracked separately.
- Framing (evaluated per delivered FLIT; in_pkt resets to 0):
  - hdr && in_pkt: set err_hdr_in_pkt. Packet restarts.
  - !hdr && !in_pkt: set err_no_hdr. FLIT is still delivered.
  - tail: in_pkt <= 0, pkt_cnt += 1. pkt_cnt wraps at 2^CNT_W.
  - hdr && !tail: in_pkt <= 1.
  - hdr && tail: single-FLIT packet; in_pkt stays 0.
- Sticky errors: set one cycle after the offending handshake and held until err_clr. If a set and err_clr occur in the same cycle, set wins.
- Throughput: 1 FLIT per clk. Input sustains full rate only when the average number of valid lanes per beat is ≤ 1.

Test Plan:
- FPW=2, beat Valid=11, Hdr=01, Tail=10, data lanes A/B, ready=1 -> flits A (hdr=1), then B (tail=1) on consecutive cycles; pkt_cnt=1; no errors.
- Sparse beat Valid=10, Hdr=10, Tail=10, lane1=C -> single flit C with hdr=tail=1; lane0 never output; pkt_cnt increments by 1.
- m_flit_ready=0, push 5 fully valid beats -> fifo_level=4, s_tready=0, 5th beat held. Raise ready -> 8 flits in lane/beat order, then 5th beat's flits; fifo_level returns to 0.
- Beat with Valid=00 -> s_tready=1, fifo_level stays 0, m_flit_valid stays 0.
- Hdr flit (no tail), then another hdr flit -> err_hdr_in_pkt=1 the cycle after the second handshake. Pulse err_clr -> 0. Tail-only flit with no open packet -> err_no_hdr=1.
- 3-flit packet; assert res for 1 cycle after first flit -> fifo_level=0, pkt_cnt=0, outputs 0. A following clean 2-flit packet gives pkt_cnt=1, no errors.
